fwd_hazard_ctrl: RTL and testbench
==================================

Name: fwd_hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage core.
- Tracks destination registers of instructions in the EX, MEM and WB stages in internal shadow registers.
- Drives the 2-bit select lines of the two EX-stage operand 3-to-1 muxes (sel 00 = register-file/ID-EX value, 01 = WB result, 10 = MEM result).
- Asserts a load-use stall, inserts bubbles on stall or branch flush, and keeps a saturating stall counter.

Parameters:
REG_ADDR_W, 5, register index width
CNT_W, 16, stall counter width

Ports:
clk  input  1  core clock, rising-edge
rst_n  input  1  asynchronous active-low reset
id_valid  input  1  ID stage holds a real instruction
id_rs1  input  REG_ADDR_W  source register 1 of ID instruction
id_rs2  input  REG_ADDR_W  source register 2 of ID instruction
id_use_rs1  input  1  ID instruction reads rs1
id_use_rs2  input  1  ID instruction reads rs2
id_rd  input  REG_ADDR_W  destination of ID instruction
id_reg_write  input  1  ID instruction writes rd
id_mem_read  input  1  ID instruction is a load
ex_flush  input  1  branch/jump resolved taken in EX; kill IF/ID
stall  output  1  hold PC and IF/ID register this cycle (combinational)
fwd_a_sel  output  2  EX operand A mux select (registered)
fwd_b_sel  output  2  EX operand B mux select (registered)
stall_count  output  CNT_W  number of cycles stall was asserted, saturating

Behaviour:
- Shadow stages EX, MEM and WB each hold {valid, rd, reg_write, mem_read}.
- Reset (rst_n low, async): all shadow stages are invalid with zero fields; fwd_a_sel = fwd_b_sel = 2'b00; stall_count = 0. stall is 0 since the EX stage is invalid.
- "Producer in stage S matches r" means: S.valid && S.reg_write && S.rd != 0 && S.rd == r.
- load_use = id_valid && EX.valid && EX.mem_read && EX.rd != 0 && ((id_use_rs1 && EX.rd == id_rs1) || (id_use_rs2 && EX.rd == id_rs2)).
- stall = load_use && !ex_flush. Flush has priority: the stalled ID instruction is being killed anyway.
- Every rising edge, MEM moves into WB and EX moves into MEM unconditionally; the shadow pipe never freezes, because only IF/ID holds on a stall.
- EX-stage update on each edge:
  - ex_flush = 1: EX becomes a bubble (valid = 0); fwd_a_sel and fwd_b_sel load 00.
  - else stall = 1: EX becomes a bubble; fwd sels load 00.
  - else: EX loads {id_valid, id_rd, id_reg_write, id_mem_read}; fwd sels load the computed next values below.
- Next-value select, per operand (A uses rs1/id_use_rs1, B uses rs2/id_use_rs2):
  - If the operand is unused or id_valid = 0: 00.
  - Else if a producer in the current EX matches: 10. That instruction will be in MEM when the consumer is in EX.
  - Else if a producer in the current MEM matches: 01. It will be in WB.
  - Else: 00.
  - The youngest producer wins (10 over 01).
  - x0 is never forwarded.
  - Encoding 11 is never produced.
- A load in EX never yields 10: a matching load triggers a stall instead. After the one-cycle bubble the load is in MEM and the consumer receives 01.
- Forwarding from WB while the consumer is in ID is not handled here; the register file is write-first transparent.
- stall_count increments by 1 on each edge where stall = 1 and holds at 2^CNT_W-1.
- Latency:
  - stall is same-cycle combinational.
  - fwd sels are valid in the cycle the consumer occupies EX, one edge after its ID cycle.
- Reset mid-operation clears all shadow stages immediately, with no pending stall or forwarding.

Test Plan:
- Reset: drive rst_n = 0 asynchronously between edges -> fwd_a_sel = fwd_b_sel = 00, stall = 0, stall_count = 0 immediately.
- EX-to-EX forwarding: issue add x5 (rd = 5, reg_write = 1), then next cycle sub with rs1 = 5, rs2 = 5 -> the following cycle fwd_a_sel = 10, fwd_b_sel = 10, stall = 0.
- MEM forwarding and priority:
  - Issue rd = 7 producer, one unrelated instruction, then consumer rs2 = 7 -> fwd_b_sel = 01.
  - Repeat with two back-to-back rd = 7 producers -> fwd_b_sel = 10.
- Load-use: issue lw x3, then consumer rs1 = 3 -> stall = 1 for exactly 1 cycle and stall_count = 1. The consumer then enters EX with fwd_a_sel = 01.
- Flush over stall: lw x3 in EX, consumer rs1 = 3 in ID, ex_flush = 1 -> stall = 0, stall_count unchanged, next fwd sels = 00, EX bubble.
- x0 and saturation:
  - Producer rd = 0 followed by consumer rs1 = 0 -> fwd_a_sel = 00.
  - With CNT_W = 2, force 5 load-use stalls -> stall_count = 3.

Source files
------------

// File: rtl/fwd_hazard_ctrl_if.sv
// ID-stage hazard inputs and EX-stage forwarding/stall outputs of the core pipeline.
// The master side drives the decoded ID instruction; the slave side is the hazard controller.
interface fwd_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_use_rs1;
    logic                  id_use_rs2;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_reg_write;
    logic                  id_mem_read;
    logic                  ex_flush;
    logic                  stall;
    logic [1:0]            fwd_a_sel;
    logic [1:0]            fwd_b_sel;
    logic [CNT_W-1:0]      stall_count;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_reg_write, id_mem_read, ex_flush,
        input  stall, fwd_a_sel, fwd_b_sel, stall_count
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_reg_write, id_mem_read, ex_flush,
        output stall, fwd_a_sel, fwd_b_sel, stall_count
    );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Load-use stall and EX operand forwarding control for the 5-stage core.
// Shadows rd/write/load info of EX, MEM and WB; forwarding selects are registered into EX.
module fwd_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    fwd_hazard_ctrl_if.slave bus
);
    typedef struct packed {
        logic                  vld;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
    } shadow_t;

    localparam shadow_t BUBBLE = '0;

    shadow_t          ex_q, ex_d, mem_q, wb_q;
    logic [1:0]       fwd_a_sel_q, fwd_a_sel_d;
    logic [1:0]       fwd_b_sel_q, fwd_b_sel_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic             load_use;
    logic             stall;

    function automatic logic producer_match(shadow_t s, logic [REG_ADDR_W-1:0] r);
        return s.vld && s.reg_write && (s.rd != '0) && (s.rd == r);
    endfunction

    // Youngest producer wins: EX (will be in MEM) beats MEM (will be in WB).
    function automatic logic [1:0] next_sel(logic used, logic [REG_ADDR_W-1:0] r,
                                            shadow_t ex, shadow_t mem);
        if (!used)                   return 2'b00;
        if (producer_match(ex, r))   return 2'b10;
        if (producer_match(mem, r))  return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    always_comb begin
        load_use = bus.id_valid && ex_q.vld && ex_q.mem_read && (ex_q.rd != '0) &&
                   ((bus.id_use_rs1 && (ex_q.rd == bus.id_rs1)) ||
                    (bus.id_use_rs2 && (ex_q.rd == bus.id_rs2)));
        // The instruction being stalled is killed by a flush anyway.
        stall = load_use && !bus.ex_flush;

        ex_d          = BUBBLE;
        fwd_a_sel_d   = 2'b00;
        fwd_b_sel_d   = 2'b00;
        stall_count_d = stall ? sat_inc(stall_count_q) : stall_count_q;

        // Non-instructions enter EX as clean bubbles so an invalid stage never carries fields.
        if (!bus.ex_flush && !stall && bus.id_valid) begin
            ex_d.vld       = 1'b1;
            ex_d.rd        = bus.id_rd;
            ex_d.reg_write = bus.id_reg_write;
            ex_d.mem_read  = bus.id_mem_read;
            fwd_a_sel_d    = next_sel(bus.id_use_rs1, bus.id_rs1, ex_q, mem_q);
            fwd_b_sel_d    = next_sel(bus.id_use_rs2, bus.id_rs2, ex_q, mem_q);
        end
    end

    // EX -> MEM -> WB advance every edge; only IF/ID holds on a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q          <= BUBBLE;
            mem_q         <= BUBBLE;
            wb_q          <= BUBBLE;
            fwd_a_sel_q   <= 2'b00;
            fwd_b_sel_q   <= 2'b00;
            stall_count_q <= '0;
        end else begin
            ex_q          <= ex_d;
            mem_q         <= ex_q;
            wb_q          <= mem_q;
            fwd_a_sel_q   <= fwd_a_sel_d;
            fwd_b_sel_q   <= fwd_b_sel_d;
            stall_count_q <= stall_count_d;
        end
    end

    a_wb_bubble_clean: assert property (@(posedge clk) disable iff (!rst_n)
        !wb_q.vld |-> (wb_q.rd == '0 && !wb_q.reg_write && !wb_q.mem_read));

    assign bus.stall       = stall;
    assign bus.fwd_a_sel   = fwd_a_sel_q;
    assign bus.fwd_b_sel   = fwd_b_sel_q;
    assign bus.stall_count = stall_count_q;
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed and random checks of fwd_hazard_ctrl against a queue-based pipeline model.
// Two instances share stimulus: default 16-bit counter and a 2-bit counter for saturation.
module tb_fwd_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic       id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
    logic       id_reg_write = 1'b0, id_mem_read = 1'b0, ex_flush = 1'b0;

    int checks = 0;
    int failures = 0;
    int nstall = 0;
    bit last_stall = 1'b0;

    typedef struct {
        bit v;
        int rd;
        bit rw;
        bit mr;
    } ent_t;
    ent_t pipe[$];   // [0] = EX, [1] = MEM, [2] = WB

    fwd_hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(16)) bus16 ();
    fwd_hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(2))  bus2 ();

    assign bus16.id_valid = id_valid;     assign bus2.id_valid = id_valid;
    assign bus16.id_rs1 = id_rs1;         assign bus2.id_rs1 = id_rs1;
    assign bus16.id_rs2 = id_rs2;         assign bus2.id_rs2 = id_rs2;
    assign bus16.id_use_rs1 = id_use_rs1; assign bus2.id_use_rs1 = id_use_rs1;
    assign bus16.id_use_rs2 = id_use_rs2; assign bus2.id_use_rs2 = id_use_rs2;
    assign bus16.id_rd = id_rd;           assign bus2.id_rd = id_rd;
    assign bus16.id_reg_write = id_reg_write; assign bus2.id_reg_write = id_reg_write;
    assign bus16.id_mem_read = id_mem_read;   assign bus2.id_mem_read = id_mem_read;
    assign bus16.ex_flush = ex_flush;     assign bus2.ex_flush = ex_flush;

    fwd_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
    fwd_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(2))  dut2  (.clk(clk), .rst_n(rst_n), .bus(bus2));

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit writes(ent_t e, int r);
        return e.v && e.rw && e.rd != 0 && e.rd == r;
    endfunction

    function automatic int exp_sel(bit used, int r);
        if (!used || !id_valid) return 0;
        if (writes(pipe[0], r)) return 2;
        if (writes(pipe[1], r)) return 1;
        return 0;
    endfunction

    function automatic int min_i(int a, int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_clear();
        ent_t b = '{v: 0, rd: 0, rw: 0, mr: 0};
        pipe = {b, b, b};
        nstall = 0;
        last_stall = 0;
    endtask

    // Called at a negedge with ID inputs already set; returns at the next negedge.
    task automatic cycle();
        bit   lu, st;
        int   ea, eb;
        ent_t n;
        #1;
        lu = id_valid && pipe[0].v && pipe[0].mr && pipe[0].rd != 0 &&
             ((id_use_rs1 && pipe[0].rd == int'(id_rs1)) ||
              (id_use_rs2 && pipe[0].rd == int'(id_rs2)));
        st = lu && !ex_flush;
        chk("stall", 32'(bus16.stall), 32'(st));
        chk("stall_w2", 32'(bus2.stall), 32'(st));
        n = '{v: 0, rd: 0, rw: 0, mr: 0};
        ea = 0;
        eb = 0;
        if (!ex_flush && !st) begin
            ea = exp_sel(id_use_rs1, int'(id_rs1));
            eb = exp_sel(id_use_rs2, int'(id_rs2));
            n  = '{v: id_valid, rd: int'(id_rd), rw: id_reg_write, mr: id_mem_read};
        end
        if (st) nstall++;
        @(posedge clk);
        #1;
        pipe.push_front(n);
        void'(pipe.pop_back());
        last_stall = st;
        chk("fwd_a", 32'(bus16.fwd_a_sel), 32'(ea));
        chk("fwd_b", 32'(bus16.fwd_b_sel), 32'(eb));
        chk("fwd_a_w2", 32'(bus2.fwd_a_sel), 32'(ea));
        chk("fwd_b_w2", 32'(bus2.fwd_b_sel), 32'(eb));
        chk("cnt16", 32'(bus16.stall_count), 32'(min_i(nstall, 65535)));
        chk("cnt2", 32'(bus2.stall_count), 32'(min_i(nstall, 3)));
        @(negedge clk);
    endtask

    task automatic issue(bit v, int rs1, int rs2, bit u1, bit u2, int rd, bit rw, bit mr, bit fl);
        id_valid = v; id_rs1 = 5'(rs1); id_rs2 = 5'(rs2);
        id_use_rs1 = u1; id_use_rs2 = u2; id_rd = 5'(rd);
        id_reg_write = rw; id_mem_read = mr; ex_flush = fl;
        cycle();
    endtask

    task automatic nop();
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Async reset asserted mid-cycle; outputs must clear without a clock edge.
    task automatic apply_reset(string tag);
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        chk({tag, "_stall"}, 32'(bus16.stall), 0);
        chk({tag, "_a"}, 32'(bus16.fwd_a_sel), 0);
        chk({tag, "_b"}, 32'(bus16.fwd_b_sel), 0);
        chk({tag, "_cnt"}, 32'(bus16.stall_count), 0);
        chk({tag, "_cnt2"}, 32'(bus2.stall_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_clear();
        @(posedge clk);
        #1;
        chk("por_a", 32'(bus16.fwd_a_sel), 0);
        chk("por_b", 32'(bus16.fwd_b_sel), 0);
        chk("por_stall", 32'(bus16.stall), 0);
        chk("por_cnt", 32'(bus16.stall_count), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // EX-to-EX forwarding: add x5 then sub x6, x5, x5
        issue(1, 0, 0, 0, 0, 5, 1, 0, 0);
        issue(1, 5, 5, 1, 1, 6, 1, 0, 0);
        chk("exex_a", 32'(bus16.fwd_a_sel), 2);
        chk("exex_b", 32'(bus16.fwd_b_sel), 2);
        chk("exex_stall", 32'(bus16.stall), 0);

        apply_reset("rst_mid");

        // MEM forwarding: producer x7, unrelated, consumer rs2 = 7
        issue(1, 0, 0, 0, 0, 7, 1, 0, 0);
        issue(1, 1, 2, 1, 1, 9, 1, 0, 0);
        issue(1, 4, 7, 1, 1, 10, 1, 0, 0);
        chk("mem_b", 32'(bus16.fwd_b_sel), 1);
        // Priority: two back-to-back x7 producers
        issue(1, 0, 0, 0, 0, 7, 1, 0, 0);
        issue(1, 0, 0, 0, 0, 7, 1, 0, 0);
        issue(1, 4, 7, 1, 1, 11, 1, 0, 0);
        chk("prio_b", 32'(bus16.fwd_b_sel), 2);

        apply_reset("rst_lu");

        // Load-use: lw x3; consumer rs1 = 3 held one cycle in ID
        issue(1, 0, 0, 0, 0, 3, 1, 1, 0);
        issue(1, 3, 0, 1, 0, 12, 1, 0, 0);
        chk("lu_stall_seen", 32'(last_stall), 1);
        chk("lu_cnt", 32'(bus16.stall_count), 1);
        issue(1, 3, 0, 1, 0, 12, 1, 0, 0);
        chk("lu_once", 32'(last_stall), 0);
        chk("lu_a", 32'(bus16.fwd_a_sel), 1);

        // Flush beats stall
        issue(1, 0, 0, 0, 0, 3, 1, 1, 0);
        issue(1, 3, 0, 1, 0, 12, 1, 0, 1);
        chk("fl_nostall", 32'(last_stall), 0);
        chk("fl_cnt", 32'(bus16.stall_count), 1);
        chk("fl_a", 32'(bus16.fwd_a_sel), 0);

        // x0 never forwarded
        issue(1, 0, 0, 0, 0, 0, 1, 0, 0);
        issue(1, 0, 0, 1, 1, 13, 1, 0, 0);
        chk("x0_a", 32'(bus16.fwd_a_sel), 0);

        // Saturation of the 2-bit counter
        for (int k = 0; k < 5; k++) begin
            issue(1, 0, 0, 0, 0, 3, 1, 1, 0);
            issue(1, 3, 0, 1, 0, 12, 1, 0, 0);
            issue(1, 3, 0, 1, 0, 12, 1, 0, 0);
        end
        chk("sat_cnt2", 32'(bus2.stall_count), 3);
        chk("sat_cnt16", 32'(bus16.stall_count), 6);

        // Random traffic; a stalled ID instruction is re-presented unchanged
        for (int i = 0; i < 400; i++) begin
            if (!last_stall) begin
                id_valid     = ($urandom_range(0, 9) != 0);
                id_rs1       = 5'($urandom_range(0, 3));
                id_rs2       = 5'($urandom_range(0, 3));
                id_use_rs1   = 1'($urandom_range(0, 1));
                id_use_rs2   = 1'($urandom_range(0, 1));
                id_rd        = 5'($urandom_range(0, 3));
                id_reg_write = ($urandom_range(0, 3) != 0);
                id_mem_read  = ($urandom_range(0, 2) == 0);
            end
            ex_flush = ($urandom_range(0, 9) == 0);
            cycle();
        end

        apply_reset("rst_end");
        nop();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
